// File: rtl/ecg_beat_analyzer_if.sv
`default_nettype none
// ============================================================================
// Module      : ecg_beat_analyzer_if
// Description : ECG FIFO word stream from the MAX30003 driver to the beat
//               analyzer (raw 24-bit word plus one-cycle valid strobe).
// Revision    : 1.0 - initial release
// ============================================================================
interface ecg_beat_analyzer_if;
  logic [23:0] fifo_word;
  logic        fifo_word_valid;

  modport master (output fifo_word, output fifo_word_valid);
  modport slave  (input  fifo_word, input  fifo_word_valid);
endinterface
`default_nettype wire

// File: rtl/ecg_beat_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : ecg_beat_analyzer
// Description : ETAG decode of MAX30003 ECG FIFO words, threshold/refractory
//               R-peak detector, RR interval measurement and heart rate via
//               a 16-bit restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
module ecg_beat_analyzer #(
  parameter int FS_HZ           = 128,
  parameter int REFRACT_SAMPLES = 32,
  parameter int RR_TIMEOUT      = 512
) (
  input  wire                  clk,
  input  wire                  rst_n,
  ecg_beat_analyzer_if.slave   fifo,
  input  wire signed [17:0]    threshold,
  output logic signed [17:0]   ecg_data,
  output logic                 ecg_data_valid,
  output logic                 beat_pulse,
  output logic [15:0]          rr_interval,
  output logic [15:0]          heart_rate,
  output logic                 hr_valid,
  output logic                 rhythm_lost,
  output logic                 fifo_ovf
);

  localparam logic [15:0] HR_NUM    = 16'(60 * FS_HZ);
  localparam logic [16:0] TIMEOUT_W = 17'(RR_TIMEOUT);
  localparam int          RW        = $clog2(REFRACT_SAMPLES + 1);
  localparam logic [RW-1:0] REFR_LAST = RW'(REFRACT_SAMPLES);

  typedef enum logic [0:0] {
    ARMED   = 1'b0,
    REFRACT = 1'b1
  } state_t;

  state_t r_state, w_state_nx;

  logic          r_rst_meta, r_rst_n;
  logic [15:0]   r_counter;
  logic          r_have_prev;
  logic [RW-1:0] r_refr_cnt;
  logic          r_div_start;
  logic          r_busy;
  logic [4:0]    r_bit_cnt;
  logic [15:0]   r_dvd, r_rem, r_divisor;

  logic [2:0]          w_etag;
  logic signed [17:0]  w_sample;
  logic                w_accept, w_ovf, w_beat, w_timeout;
  logic [16:0]         w_cnt_inc;
  logic [RW-1:0]       w_refr_inc;
  logic [16:0]         w_rem_sh;
  logic                w_ge;
  logic [15:0]         w_rem_nx, w_q_nx;
  logic                unused_ptag;

  // Tag decode and detector decisions for the word presented this cycle.
  assign w_etag      = fifo.fifo_word[5:3];
  assign w_sample    = fifo.fifo_word[23:6];
  assign unused_ptag = ^fifo.fifo_word[2:0];
  assign w_accept    = fifo.fifo_word_valid && !w_etag[2];
  assign w_ovf       = fifo.fifo_word_valid && (w_etag == 3'b111);
  assign w_cnt_inc   = {1'b0, r_counter} + 17'd1;
  assign w_refr_inc  = r_refr_cnt + RW'(1);
  assign w_beat      = w_accept && (r_state == ARMED) && (w_sample > threshold);
  // A beat on the same sample takes precedence over the timeout.
  assign w_timeout   = w_accept && !w_beat && (w_cnt_inc == TIMEOUT_W);

  // One restoring-division step: shift in next dividend bit, trial subtract.
  assign w_rem_sh = {r_rem, r_dvd[15]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_divisor});
  assign w_rem_nx = w_ge ? 16'(w_rem_sh - {1'b0, r_divisor}) : w_rem_sh[15:0];
  assign w_q_nx   = {r_dvd[14:0], w_ge};

  // Reset synchronizer: assert immediately, release on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  // Detector state register.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) r_state <= ARMED;
    else          r_state <= w_state_nx;
  end

  // Detector next state: only accepted samples (or overflow) move the FSM.
  always_comb begin
    w_state_nx = r_state;
    if (w_ovf) begin
      w_state_nx = ARMED;
    end else if (w_accept) begin
      case (r_state)
        ARMED:   if (w_beat) w_state_nx = REFRACT;
        REFRACT: if (w_refr_inc == REFR_LAST) w_state_nx = ARMED;
        default: w_state_nx = ARMED;
      endcase
      if (w_timeout) w_state_nx = ARMED;
    end
  end

  // Sample capture, sample counter, refractory count and RR measurement.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      ecg_data       <= '0;
      ecg_data_valid <= 1'b0;
      beat_pulse     <= 1'b0;
      rr_interval    <= '0;
      fifo_ovf       <= 1'b0;
      r_counter      <= '0;
      r_have_prev    <= 1'b0;
      r_refr_cnt     <= '0;
      r_div_start    <= 1'b0;
    end else begin
      ecg_data_valid <= 1'b0;
      beat_pulse     <= 1'b0;
      r_div_start    <= 1'b0;
      if (w_ovf) begin
        fifo_ovf    <= 1'b1;
        r_counter   <= '0;
        r_have_prev <= 1'b0;
      end else if (w_accept) begin
        ecg_data       <= w_sample;
        ecg_data_valid <= 1'b1;
        if (w_beat) begin
          beat_pulse  <= 1'b1;
          r_refr_cnt  <= '0;
          r_counter   <= '0;
          r_have_prev <= 1'b1;
          if (r_have_prev) begin
            rr_interval <= w_cnt_inc[15:0];
            r_div_start <= 1'b1;
          end
        end else begin
          r_counter <= w_cnt_inc[16] ? 16'hFFFF : w_cnt_inc[15:0];
          if (r_state == REFRACT) r_refr_cnt <= w_refr_inc;
          if (w_timeout) r_have_prev <= 1'b0;
        end
      end
    end
  end

  // Heart-rate divider and rhythm status; overflow or restart aborts a run.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      heart_rate  <= '0;
      hr_valid    <= 1'b0;
      rhythm_lost <= 1'b1;
      r_busy      <= 1'b0;
      r_bit_cnt   <= '0;
      r_dvd       <= '0;
      r_rem       <= '0;
      r_divisor   <= '0;
    end else begin
      hr_valid <= 1'b0;
      if (w_ovf) begin
        r_busy      <= 1'b0;
        rhythm_lost <= 1'b1;
      end else if (r_div_start) begin
        r_busy    <= 1'b1;
        r_bit_cnt <= 5'd16;
        r_dvd     <= HR_NUM;
        r_rem     <= '0;
        r_divisor <= rr_interval;
      end else if (r_busy) begin
        r_rem     <= w_rem_nx;
        r_dvd     <= w_q_nx;
        r_bit_cnt <= r_bit_cnt - 5'd1;
        if (r_bit_cnt == 5'd1) begin
          r_busy      <= 1'b0;
          heart_rate  <= w_q_nx;
          hr_valid    <= 1'b1;
          rhythm_lost <= 1'b0;
        end
      end
      if (w_timeout) begin
        heart_rate  <= '0;
        rhythm_lost <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/ecg_beat_analyzer.md
Name: ecg_beat_analyzer

Overview:
- Sits directly downstream of the MAX30003 driver and consumes each 24-bit ECG FIFO word it reads.
- Decodes the ETAG field, discards empty and overflow words, and outputs sign-correct 18-bit ECG samples.
- Detects R-peaks with a threshold crossing plus a refractory period, measures the RR interval in samples, and computes heart rate in BPM with a sequential divider.
- Its heart_rate and rr_interval outputs drive the system-level HR/RR registers.

Parameters:
- FS_HZ, 128: ECG sample rate in samples/s. HR_NUM = 60*FS_HZ, which must fit in 16 bits.
- REFRACT_SAMPLES, 32: accepted samples ignored after a beat (250 ms at 128 sps).
- RR_TIMEOUT, 512: samples without a beat before the rhythm is declared lost (4 s).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fifo_word  in  24  raw ECG FIFO word: [23:6] data, [5:3] ETAG, [2:0] PTAG
- fifo_word_valid  in  1  one-cycle strobe; fifo_word is valid this cycle
- threshold  in  18  signed R-peak threshold, quasi-static
- ecg_data  out  18  signed ECG sample (two's complement, fifo_word[23:6])
- ecg_data_valid  out  1  one-cycle pulse with each accepted sample
- beat_pulse  out  1  one-cycle pulse on a detected R-peak
- rr_interval  out  16  samples between the last two beats
- heart_rate  out  16  BPM, floor(HR_NUM / rr_interval)
- hr_valid  out  1  one-cycle pulse when heart_rate updates
- rhythm_lost  out  1  level; high while no valid beat pair exists
- fifo_ovf  out  1  sticky; set by an overflow tag, cleared only by reset

Behaviour:
- Reset: every output is 0, except rhythm_lost = 1. The FSM is in ARMED, the sample counter is 0, have_prev = 0, and the divider is idle. Reset asserts immediately and releases synchronously to clk.
- ETAG decode on the fifo_word_valid cycle T:
  - 000, 001, 010, 011 → accepted sample.
  - 110 (empty) → ignored, no state change.
  - 111 (overflow) → fifo_ovf <= 1. FSM goes to ARMED, counter <= 0, have_prev <= 0, rhythm_lost <= 1.
  - 100, 101 → ignored.
- Accepted sample: ecg_data <= fifo_word[23:6] and ecg_data_valid pulses at T+1.
- Sample counter (16 bits) advances by 1 on each accepted sample, saturating at 0xFFFF. Each beat handles the counter as defined under ARMED below.
- Detector FSM, evaluated only on accepted samples:
  - ARMED: if the signed sample > the signed threshold (strict), it is a beat. Then beat_pulse pulses at T+1, refr_cnt <= 0, and the FSM goes to REFRACT.
    - If have_prev = 1: rr_interval <= counter + 1 and the divider starts at T+1.
    - The counter is then set to 0, and have_prev is set to 1.
  - REFRACT: the sample is never a beat. refr_cnt increments; when it reaches REFRACT_SAMPLES, the FSM returns to ARMED, so the next sample is eligible.
- Timeout: when counter + 1 reaches RR_TIMEOUT without a beat:
  - have_prev <= 0, rhythm_lost <= 1, heart_rate <= 0.
  - The FSM stays in or returns to ARMED.
  - The next beat re-arms measurement but does not produce an HR.
- rhythm_lost clears on the cycle hr_valid pulses.
- Divider: restoring, unsigned, 16-bit.
  - Loads at T+1 and iterates 16 cycles (T+2..T+17).
  - heart_rate <= quotient and hr_valid pulses at T+18. The remainder is discarded.
  - The divisor is always ≥ REFRACT_SAMPLES+1, so divide-by-zero cannot occur.
  - A new start while busy aborts the running division and restarts with the new rr_interval; no hr_valid is issued for the aborted division.
- rr_interval and heart_rate hold until their next update.
- Reset mid-division aborts it with no hr_valid. Overflow mid-division also aborts it, with no hr_valid.
- Simultaneous timeout and beat on the same sample: the beat wins and the timeout is suppressed.

Test Plan:
- Reset, then 3 samples above threshold 1000 spaced 128 accepted samples apart → beat_pulse ×3; after the 2nd and 3rd beats rr_interval = 128, heart_rate = 60, hr_valid exactly 18 cycles after each input strobe; rhythm_lost falls after the 2nd beat.
- Beats spaced 100 samples apart → rr_interval = 100, heart_rate = 76 (7680/100 floored).
- Second above-threshold sample 10 samples after a beat (inside refractory) → no beat_pulse; the next crossing at 100 samples after the first beat gives rr_interval = 100.
- Interleaved ETAG=110 words between samples → no ecg_data_valid for them and the counter is unaffected; rr_interval is unchanged vs. the same stream without them.
- ETAG=111 mid-rhythm → fifo_ovf = 1 and stays 1; rhythm_lost = 1; next beat gives no hr_valid; the following beat 128 samples later restores heart_rate = 60.
- No beat for 512 samples → heart_rate = 0, rhythm_lost = 1. Separately, assert rst_n low during a divider run → all outputs at reset values, no hr_valid.
